// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the instruction-fetch / load-store RAM arbiter:
// FSM encodings, port identifiers and the legacy reset/enable levels.
package mem_bus_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  localparam logic PORT_IF  = 1'b0;
  localparam logic PORT_MEM = 1'b1;

  localparam logic RST_ENABLE  = 1'b1;
  localparam logic RST_DISABLE = 1'b0;
  localparam logic ENABLE      = 1'b1;
  localparam logic DISABLE     = 1'b0;

  // RAM_LAT is limited to 1..7, so three bits hold the latency count.
  localparam int CNT_W = 3;

  typedef logic [CNT_W-1:0] lat_cnt_t;
  typedef logic             port_id_t;

  function automatic port_id_t other_port(input port_id_t p);
    return (p == PORT_IF) ? PORT_MEM : PORT_IF;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and load/store requests.
// MEM_ARB_RR_EN defined: round-robin on conflict; undefined: load/store wins.
module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic     i_if_req,
  input  logic     i_mem_req,
  input  port_id_t i_last_grant,
  output logic     o_valid,
  output port_id_t o_port
);

  logic w_both;

  assign w_both  = i_if_req & i_mem_req;
  assign o_valid = i_if_req | i_mem_req;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    o_port = PORT_IF;
    if (w_both) begin
      o_port = other_port(i_last_grant);
    end else if (i_mem_req) begin
      o_port = PORT_MEM;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = i_last_grant;

  // The older load/store instruction has to drain before fetch proceeds.
  always_comb begin
    o_port = PORT_IF;
    if (w_both || i_mem_req) begin
      o_port = PORT_MEM;
    end
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port RAM arbiter for the core's fetch and load/store ports with
// registered RAM control; arbitration mode selected by MEM_ARB_RR_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no transaction; pick a winner and latch its request fields
// ST_ACCESS | ram_ce asserted for one cycle, latency counter loaded
// ST_WAIT   | RAM_LAT cycles; last cycle acks the granted port
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,

  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic [DATA_W-1:0]   o_if_rdata,
  output logic                o_if_ack,

  input  logic                i_mem_req,
  input  logic                i_mem_we,
  input  logic [ADDR_W-1:0]   i_mem_addr,
  input  logic [DATA_W-1:0]   i_mem_wdata,
  input  logic [DATA_W/8-1:0] i_mem_sel,
  output logic [DATA_W-1:0]   o_mem_rdata,
  output logic                o_mem_ack,

  output logic                o_ram_ce,
  output logic                o_ram_we,
  output logic [ADDR_W-1:0]   o_ram_addr,
  output logic [DATA_W-1:0]   o_ram_wdata,
  output logic [DATA_W/8-1:0] o_ram_sel,
  input  logic [DATA_W-1:0]   i_ram_rdata,

  output logic                o_stallreq_if,
  output logic                o_stallreq_mem
);

  logic [1:0]          r_state;
  lat_cnt_t            r_cnt;
  port_id_t            r_grant;
  port_id_t            r_last;

  logic                r_ram_ce;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic [DATA_W/8-1:0] r_ram_sel;

  logic                w_pick_valid;
  port_id_t            w_pick_port;
  logic                w_done;
  logic                w_if_ack;
  logic                w_mem_ack;

  mem_arb_pick u_pick (
    .i_if_req     (i_if_req),
    .i_mem_req    (i_mem_req),
    .i_last_grant (r_last),
    .o_valid      (w_pick_valid),
    .o_port       (w_pick_port)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst == RST_ENABLE) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_grant     <= PORT_IF;
      r_last      <= PORT_IF;
      r_ram_ce    <= DISABLE;
      r_ram_we    <= DISABLE;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_sel   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_state  <= ST_ACCESS;
            r_grant  <= w_pick_port;
            r_last   <= w_pick_port;
            r_ram_ce <= ENABLE;
            if (w_pick_port == PORT_MEM) begin
              r_ram_we    <= i_mem_we;
              r_ram_addr  <= i_mem_addr;
              r_ram_wdata <= i_mem_wdata;
              r_ram_sel   <= i_mem_sel;
            end else begin
              // Fetches always read a full word.
              r_ram_we    <= DISABLE;
              r_ram_addr  <= i_if_addr;
              r_ram_wdata <= '0;
              r_ram_sel   <= '1;
            end
          end
        end
        ST_ACCESS: begin
          r_state  <= ST_WAIT;
          r_cnt    <= CNT_W'(RAM_LAT);
          r_ram_ce <= DISABLE;
          r_ram_we <= DISABLE;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_cnt    <= '0;
          r_ram_ce <= DISABLE;
          r_ram_we <= DISABLE;
        end
      endcase
    end
  end

  // Read data is only valid in the final WAIT cycle, so ack passes it through.
  assign w_done    = (r_state == ST_WAIT) && (r_cnt == CNT_W'(1));
  assign w_if_ack  = w_done && (r_grant == PORT_IF);
  assign w_mem_ack = w_done && (r_grant == PORT_MEM);

  assign o_if_ack    = w_if_ack;
  assign o_mem_ack   = w_mem_ack;
  assign o_if_rdata  = w_if_ack  ? i_ram_rdata : '0;
  assign o_mem_rdata = w_mem_ack ? i_ram_rdata : '0;

  assign o_ram_ce    = r_ram_ce;
  assign o_ram_we    = r_ram_we;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_ram_sel   = r_ram_sel;

  assign o_stallreq_if  = i_if_req  & ~w_if_ack;
  assign o_stallreq_mem = i_mem_req & ~w_mem_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised bench for mem_bus_arbiter: two instances (RAM_LAT 1 and 3)
// checked every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int  NDUT  = 2;
  localparam int  LAT_A = 1;
  localparam int  LAT_B = 3;
  localparam int  NCYC  = 1400;
  localparam bit  P_IF  = 1'b0;
  localparam bit  P_MEM = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        if_req      [NDUT];
  logic [31:0] if_addr     [NDUT];
  logic [31:0] if_rdata    [NDUT];
  logic        if_ack      [NDUT];
  logic        mem_req     [NDUT];
  logic        mem_we      [NDUT];
  logic [31:0] mem_addr    [NDUT];
  logic [31:0] mem_wdata   [NDUT];
  logic [3:0]  mem_sel     [NDUT];
  logic [31:0] mem_rdata   [NDUT];
  logic        mem_ack     [NDUT];
  logic        ram_ce      [NDUT];
  logic        ram_we      [NDUT];
  logic [31:0] ram_addr    [NDUT];
  logic [31:0] ram_wdata   [NDUT];
  logic [3:0]  ram_sel     [NDUT];
  logic        stall_if    [NDUT];
  logic        stall_mem   [NDUT];

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT_A : LAT_B;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int LAT = (g == 0) ? LAT_A : LAT_B;
    logic [31:0] pipe [8];
    logic [31:0] ram_rdata_w;

    // Behavioural RAM: data for the ce-cycle address appears LAT cycles later.
    always @(posedge clk) begin
      for (int k = 7; k > 0; k--) pipe[k] <= pipe[k-1];
      pipe[0] <= ram_ce[g] ? rd_hash(ram_addr[g]) : $urandom;
    end
    assign ram_rdata_w = pipe[LAT-1];

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(LAT)) u_dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_if_req       (if_req[g]),
      .i_if_addr      (if_addr[g]),
      .o_if_rdata     (if_rdata[g]),
      .o_if_ack       (if_ack[g]),
      .i_mem_req      (mem_req[g]),
      .i_mem_we       (mem_we[g]),
      .i_mem_addr     (mem_addr[g]),
      .i_mem_wdata    (mem_wdata[g]),
      .i_mem_sel      (mem_sel[g]),
      .o_mem_rdata    (mem_rdata[g]),
      .o_mem_ack      (mem_ack[g]),
      .o_ram_ce       (ram_ce[g]),
      .o_ram_we       (ram_we[g]),
      .o_ram_addr     (ram_addr[g]),
      .o_ram_wdata    (ram_wdata[g]),
      .o_ram_sel      (ram_sel[g]),
      .i_ram_rdata    (ram_rdata_w),
      .o_stallreq_if  (stall_if[g]),
      .o_stallreq_mem (stall_mem[g])
    );
  end

  // Reference model: one record of the last grant per instance.
  bit          m_has   [NDUT];
  int          m_t0    [NDUT];
  bit          m_port  [NDUT];
  bit          m_we    [NDUT];
  logic [31:0] m_addr  [NDUT];
  logic [31:0] m_wdata [NDUT];
  logic [3:0]  m_sel   [NDUT];
  bit          m_last  [NDUT];
  bit          p_ackif [NDUT];
  bit          p_ackmm [NDUT];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    m_has[d]   = 1'b0;
    m_last[d]  = P_IF;
    p_ackif[d] = 1'b0;
    p_ackmm[d] = 1'b0;
  endtask

  task automatic reset_checks(input int d, input int t);
    string s;
    s = $sformatf("d%0d.t%0d.rst", d, t);
    check({s, ".ram_ce"},    64'(ram_ce[d]),    64'(0));
    check({s, ".ram_we"},    64'(ram_we[d]),    64'(0));
    check({s, ".ram_addr"},  64'(ram_addr[d]),  64'(0));
    check({s, ".ram_wdata"}, 64'(ram_wdata[d]), 64'(0));
    check({s, ".ram_sel"},   64'(ram_sel[d]),   64'(0));
    check({s, ".if_ack"},    64'(if_ack[d]),    64'(0));
    check({s, ".mem_ack"},   64'(mem_ack[d]),   64'(0));
    check({s, ".if_rdata"},  64'(if_rdata[d]),  64'(0));
    check({s, ".mem_rdata"}, 64'(mem_rdata[d]), 64'(0));
  endtask

  task automatic check_cycle(input int d, input int t);
    int    ph;
    int    lat;
    bit    ce_e, aif_e, amem_e;
    string s;
    lat    = lat_of(d);
    ph     = m_has[d] ? (t - m_t0[d]) : -1;
    ce_e   = (ph == 1);
    aif_e  = (ph == 1 + lat) && (m_port[d] == P_IF);
    amem_e = (ph == 1 + lat) && (m_port[d] == P_MEM);
    s      = $sformatf("d%0d.t%0d", d, t);

    check({s, ".ram_ce"}, 64'(ram_ce[d]), 64'(ce_e));
    if (ce_e) begin
      check({s, ".ram_we"},   64'(ram_we[d]),   64'((m_port[d] == P_MEM) ? m_we[d] : 1'b0));
      check({s, ".ram_addr"}, 64'(ram_addr[d]), 64'(m_addr[d]));
      if (m_port[d] == P_MEM) begin
        check({s, ".ram_wdata"}, 64'(ram_wdata[d]), 64'(m_wdata[d]));
        check({s, ".ram_sel"},   64'(ram_sel[d]),   64'(m_sel[d]));
      end
    end
    check({s, ".if_ack"},    64'(if_ack[d]),    64'(aif_e));
    check({s, ".mem_ack"},   64'(mem_ack[d]),   64'(amem_e));
    check({s, ".if_rdata"},  64'(if_rdata[d]),  64'(aif_e  ? rd_hash(m_addr[d]) : 32'h0));
    check({s, ".mem_rdata"}, 64'(mem_rdata[d]), 64'(amem_e ? rd_hash(m_addr[d]) : 32'h0));
    check({s, ".stall_if"},  64'(stall_if[d]),  64'(if_req[d]  & ~aif_e));
    check({s, ".stall_mem"}, 64'(stall_mem[d]), 64'(mem_req[d] & ~amem_e));
    p_ackif[d] = aif_e;
    p_ackmm[d] = amem_e;
  endtask

  // A grant is possible once the previous one has run ACCESS + RAM_LAT WAIT cycles.
  task automatic model_step(input int d, input int t);
    bit idle;
    bit win;
    if (rst) return;
    idle = !m_has[d] || ((t - m_t0[d]) >= 2 + lat_of(d));
    if (idle && (if_req[d] || mem_req[d])) begin
      if (if_req[d] && mem_req[d]) begin
`ifdef MEM_ARB_RR_EN
        win = (m_last[d] == P_IF) ? P_MEM : P_IF;
`else
        win = P_MEM;
`endif
      end else begin
        win = mem_req[d] ? P_MEM : P_IF;
      end
      m_has[d]  = 1'b1;
      m_t0[d]   = t;
      m_port[d] = win;
      m_last[d] = win;
      m_we[d]   = (win == P_MEM) ? mem_we[d] : 1'b0;
      m_addr[d] = (win == P_MEM) ? mem_addr[d] : if_addr[d];
      m_wdata[d] = mem_wdata[d];
      m_sel[d]   = mem_sel[d];
    end
  endtask

  task automatic drive(input int d, input int phase);
    if (phase == 1) begin
      if_req[d]  = 1'b1;
      mem_req[d] = 1'b1;
    end else begin
      if (if_req[d]) begin
        if (p_ackif[d]) begin
          if ($urandom_range(0, 3) != 0) if_req[d] = 1'b0;
        end else if ($urandom_range(0, 40) == 0) begin
          if_req[d] = 1'b0;
        end
      end else if ($urandom_range(0, 9) < 4) begin
        if_req[d] = 1'b1;
      end
      if (mem_req[d]) begin
        if (p_ackmm[d]) begin
          if ($urandom_range(0, 3) != 0) mem_req[d] = 1'b0;
        end else if ($urandom_range(0, 40) == 0) begin
          mem_req[d] = 1'b0;
        end
      end else if ($urandom_range(0, 9) < 4) begin
        mem_req[d] = 1'b1;
      end
    end
    if ($urandom_range(0, 2) == 0) if_addr[d] = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 2) == 0) begin
      mem_addr[d]  = $urandom & 32'hFFFF_FFFC;
      mem_wdata[d] = $urandom;
      mem_sel[d]   = 4'($urandom_range(0, 15));
      mem_we[d]    = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int phase;
    bit inject;
    for (int d = 0; d < NDUT; d++) begin
      if_req[d]    = 1'b0;
      if_addr[d]   = 32'h0;
      mem_req[d]   = 1'b0;
      mem_we[d]    = 1'b0;
      mem_addr[d]  = 32'h0;
      mem_wdata[d] = 32'h0;
      mem_sel[d]   = 4'h0;
      model_reset(d);
    end
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) reset_checks(d, -1);
    repeat (2) @(posedge clk);

    for (int t = 0; t < NCYC; t++) begin
      @(posedge clk);
      #1;
      phase = (t < 900) ? 0 : ((t < 1000) ? 1 : 2);
      rst   = 1'b0;
      for (int d = 0; d < NDUT; d++) drive(d, phase);
      inject = (t == 900) || ((phase != 1) && ($urandom_range(0, 39) == 0));
      if (inject) begin
        rst = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
          reset_checks(d, t);
          model_reset(d);
        end
      end
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        check_cycle(d, t);
        model_step(d, t);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
